// File: rtl/controlador_carga_disco_pkg.sv
// Shared definitions for the disk-to-instruction-memory boot loader:
// sequencer states, default disk size and word width.
package controlador_carga_disco_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LER      = 2'd1,
    ESCREVER = 2'd2,
    FIM      = 2'd3
  } estado_t;

  localparam int unsigned DISK_SIZE_PADRAO = 71;
  localparam int unsigned WORD_W           = 32;

endpackage

// File: rtl/controlador_carga_disco.sv
// Boot/DMA sequencer copying a block of words from disco_rigido into instruction memory.
// Optional running checksum of copied words: define CARGA_DISCO_CHECKSUM_EN.
module controlador_carga_disco
  import controlador_carga_disco_pkg::*;
#(
  parameter int unsigned DISK_SIZE = DISK_SIZE_PADRAO,
  parameter int unsigned ADDR_W    = 26,
  parameter int unsigned LEN_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inicio,
  input  logic [ADDR_W-1:0] end_origem,
  input  logic [ADDR_W-1:0] end_destino,
  input  logic [LEN_W-1:0]  tamanho,
  output logic [ADDR_W-1:0] disco_end,
  input  logic [WORD_W-1:0] disco_dado,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_end,
  output logic [WORD_W-1:0] mem_dado,
  input  logic              mem_pronto,
  output logic              ocupado,
  output logic              concluido,
  output logic              erro
`ifdef CARGA_DISCO_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0] checksum
`endif
);

  estado_t             estado, estado_prox;
  logic [ADDR_W-1:0]   origem, destino;
  logic [LEN_W-1:0]    restante;
  logic [WORD_W-1:0]   dado;
  logic [ADDR_W:0]     fim_origem;
  logic                fora_limite;
  logic                aceita_inicio;
  logic                aceita_escrita;

  // One extra bit so the bounds sum cannot wrap past the disk size.
  assign fim_origem     = {1'b0, end_origem} + (ADDR_W+1)'(tamanho);
  assign fora_limite    = fim_origem > (ADDR_W+1)'(DISK_SIZE);
  assign aceita_inicio  = (estado == IDLE) && inicio;
  assign aceita_escrita = (estado == ESCREVER) && mem_pronto;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= IDLE;
    else        estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    disco_end   = '0;
    mem_we      = 1'b0;
    mem_end     = '0;
    mem_dado    = '0;
    ocupado     = 1'b1;
    concluido   = 1'b0;
    unique case (estado)
      IDLE: begin
        ocupado = 1'b0;
        if (inicio) begin
          if (fora_limite || (tamanho == '0)) estado_prox = FIM;
          else                                estado_prox = LER;
        end
      end
      LER: begin
        disco_end   = origem;
        estado_prox = ESCREVER;
      end
      ESCREVER: begin
        mem_we   = 1'b1;
        mem_end  = destino;
        mem_dado = dado;
        if (mem_pronto) estado_prox = (restante == LEN_W'(1)) ? FIM : LER;
      end
      FIM: begin
        concluido   = 1'b1;
        estado_prox = IDLE;
      end
      default: estado_prox = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      origem   <= '0;
      destino  <= '0;
      restante <= '0;
      dado     <= '0;
      erro     <= 1'b0;
    end else begin
      if (aceita_inicio) begin
        origem   <= end_origem;
        destino  <= end_destino;
        restante <= tamanho;
        erro     <= fora_limite;
      end
      if (estado == LER) dado <= disco_dado;
      if (aceita_escrita) begin
        origem   <= origem + ADDR_W'(1);
        destino  <= destino + ADDR_W'(1);
        restante <= restante - LEN_W'(1);
      end
    end
  end

`ifdef CARGA_DISCO_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              checksum <= '0;
    else if (aceita_inicio)  checksum <= '0;
    else if (aceita_escrita) checksum <= checksum + dado;
  end
`endif

endmodule

// File: tb/tb_controlador_carga_disco.sv
// Directed bench for controlador_carga_disco with a combinational disk model and a
// memory model; checksum checks are included when CARGA_DISCO_CHECKSUM_EN is defined.
module tb_controlador_carga_disco;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inicio = 1'b0;
  logic [25:0] end_origem = '0;
  logic [25:0] end_destino = '0;
  logic [15:0] tamanho = '0;
  logic [25:0] disco_end;
  logic [31:0] disco_dado;
  logic        mem_we;
  logic [25:0] mem_end;
  logic [31:0] mem_dado;
  logic        mem_pronto = 1'b1;
  logic        ocupado;
  logic        concluido;
  logic        erro;
`ifdef CARGA_DISCO_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  logic [31:0] mem [0:255];
  logic        stall_en = 1'b0;
  logic [25:0] stall_addr = '0;
  logic [31:0] stall_dado = '0;
  int          stalls = 0;

  always #5 clock = ~clock;

  controlador_carga_disco #(.DISK_SIZE(71), .ADDR_W(26), .LEN_W(16)) dut (
    .clock(clock), .reset(reset), .inicio(inicio),
    .end_origem(end_origem), .end_destino(end_destino), .tamanho(tamanho),
    .disco_end(disco_end), .disco_dado(disco_dado),
    .mem_we(mem_we), .mem_end(mem_end), .mem_dado(mem_dado), .mem_pronto(mem_pronto),
    .ocupado(ocupado), .concluido(concluido), .erro(erro)
`ifdef CARGA_DISCO_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  function automatic logic [31:0] disk_word(input logic [25:0] a);
    return (32'h9E37_79B9 * ({6'b0, a} + 32'd1)) ^ 32'h5A5A_0F0F;
  endfunction

  assign disco_dado = (disco_end < 26'd71) ? disk_word(disco_end) : 32'hDEAD_BEEF;

  task automatic checa(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: accepted writes land here.
  always @(posedge clock) begin
    if (mem_we && mem_pronto) begin
      mem[mem_end[7:0]] = mem_dado;
      wr_cnt = wr_cnt + 1;
    end
  end

  // Back-pressure generator: withholds mem_pronto for 3 cycles on one address.
  always @(negedge clock) begin
    if (stall_en && mem_we && mem_end == stall_addr && stalls < 3) begin
      mem_pronto = 1'b0;
      stalls = stalls + 1;
      checa("stall_dado", {32'b0, mem_dado}, {32'b0, stall_dado});
    end else begin
      mem_pronto = 1'b1;
    end
  end

  task automatic run_transfer(input logic [25:0] o, input logic [25:0] d, input logic [15:0] t,
                              input int repulse, output int lat, output int wr, output int busy);
    int edges;
    int wr0;
    @(negedge clock);
    end_origem = o; end_destino = d; tamanho = t; inicio = 1'b1;
    wr0 = wr_cnt;
    @(posedge clock);
    #1 inicio = 1'b0;
    edges = 0; busy = 0; lat = -1;
    while (edges < 400) begin
      @(negedge clock);
      if (ocupado) busy++;
      if (concluido) begin
        lat = edges + 1;
        break;
      end
      if (edges == repulse) begin
        inicio = 1'b1; end_origem = 26'd0; tamanho = 16'd3; end_destino = 26'd200;
      end else begin
        inicio = 1'b0;
      end
      @(posedge clock);
      edges++;
    end
    inicio = 1'b0;
    if (lat < 0) checa("timeout", 64'd1, 64'd0);
    wr = wr_cnt - wr0;
  endtask

  initial begin
    int lat, wr, busy;
    logic [31:0] soma;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    #12;
    checa("rst_ocupado", {63'b0, ocupado}, 64'd0);
    checa("rst_concluido", {63'b0, concluido}, 64'd0);
    checa("rst_erro", {63'b0, erro}, 64'd0);
    checa("rst_mem_we", {63'b0, mem_we}, 64'd0);
    checa("rst_disco_end", {38'b0, disco_end}, 64'd0);
`ifdef CARGA_DISCO_CHECKSUM_EN
    checa("rst_checksum", {32'b0, checksum}, 64'd0);
`endif
    @(negedge clock) reset = 1'b1;

    // Full copy of words 0..46 with no back-pressure.
    run_transfer(26'd0, 26'd0, 16'd47, -1, lat, wr, busy);
    checa("t1_lat", lat, 64'd95);
    checa("t1_wr", wr, 64'd47);
    checa("t1_erro", {63'b0, erro}, 64'd0);
    soma = '0;
    for (int i = 0; i < 47; i++) begin
      checa($sformatf("t1_mem%0d", i), {32'b0, mem[i]}, {32'b0, disk_word(26'(i))});
      soma = soma + disk_word(26'(i));
    end
    @(negedge clock);
    checa("t1_pulse", {63'b0, concluido}, 64'd0);
    checa("t1_idle", {63'b0, ocupado}, 64'd0);
`ifdef CARGA_DISCO_CHECKSUM_EN
    checa("t7_checksum", {32'b0, checksum}, {32'b0, soma});
    repeat (3) @(negedge clock);
    checa("t7_checksum_hold", {32'b0, checksum}, {32'b0, soma});
`endif

    // Zero-length copy.
    run_transfer(26'd5, 26'd16, 16'd0, -1, lat, wr, busy);
    checa("t2_lat", lat, 64'd1);
    checa("t2_wr", wr, 64'd0);
    checa("t2_erro", {63'b0, erro}, 64'd0);
    checa("t2_busy", busy, 64'd1);
    @(negedge clock);
    checa("t2_idle", {63'b0, ocupado}, 64'd0);

    // Out-of-range source, then error held until the next start.
    run_transfer(26'd60, 26'd0, 16'd20, -1, lat, wr, busy);
    checa("t3_lat", lat, 64'd1);
    checa("t3_wr", wr, 64'd0);
    checa("t3_erro", {63'b0, erro}, 64'd1);
    repeat (3) @(negedge clock);
    checa("t3_erro_hold", {63'b0, erro}, 64'd1);
    run_transfer(26'd51, 26'd160, 16'd20, -1, lat, wr, busy);
    checa("t3_edge_lat", lat, 64'd41);
    checa("t3_edge_wr", wr, 64'd20);
    checa("t3_edge_erro", {63'b0, erro}, 64'd0);
    checa("t3_edge_last", {32'b0, mem[179]}, {32'b0, disk_word(26'd70)});

    // Stall on the second word.
    stalls = 0; stall_addr = 26'd101; stall_dado = disk_word(26'd11); stall_en = 1'b1;
    run_transfer(26'd10, 26'd100, 16'd4, -1, lat, wr, busy);
    stall_en = 1'b0;
    checa("t4_lat", lat, 64'd12);
    checa("t4_wr", wr, 64'd4);
    checa("t4_stalls", stalls, 64'd3);
    for (int i = 0; i < 4; i++)
      checa($sformatf("t4_mem%0d", i), {32'b0, mem[100+i]}, {32'b0, disk_word(26'(10+i))});

    // Reset in the middle of a 20-word copy.
    @(negedge clock);
    end_origem = 26'd0; end_destino = 26'd128; tamanho = 16'd20; inicio = 1'b1;
    lat = wr_cnt;
    @(posedge clock);
    #1 inicio = 1'b0;
    for (int n = 0; n < 200 && (wr_cnt - lat) < 5; n++) @(negedge clock);
    checa("t5_pre_wr", wr_cnt - lat, 64'd5);
    #1 reset = 1'b0;
    #1;
    checa("t5_ocupado", {63'b0, ocupado}, 64'd0);
    checa("t5_mem_we", {63'b0, mem_we}, 64'd0);
    checa("t5_mem_end", {38'b0, mem_end}, 64'd0);
    checa("t5_disco_end", {38'b0, disco_end}, 64'd0);
    checa("t5_concluido", {63'b0, concluido}, 64'd0);
    repeat (3) @(negedge clock);
    checa("t5_no_wr", wr_cnt - lat, 64'd5);
    reset = 1'b1;
    run_transfer(26'd5, 26'd64, 16'd3, -1, lat, wr, busy);
    checa("t5_after_lat", lat, 64'd7);
    checa("t5_after_wr", wr, 64'd3);
    checa("t5_after_mem", {32'b0, mem[66]}, {32'b0, disk_word(26'd7)});

    // Second start pulse and input changes mid-transfer are ignored.
    run_transfer(26'd20, 26'd48, 16'd10, 4, lat, wr, busy);
    checa("t6_lat", lat, 64'd21);
    checa("t6_wr", wr, 64'd10);
    for (int i = 0; i < 10; i++)
      checa($sformatf("t6_mem%0d", i), {32'b0, mem[48+i]}, {32'b0, disk_word(26'(20+i))});
    repeat (3) @(negedge clock);
    checa("t6_idle", {63'b0, ocupado}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
